// File: rtl/vga_text_pkg.sv
// Shared timing defaults, text-grid geometry and helpers for the VGA text scanner.
package vga_text_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W     = 10;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;

    localparam logic [7:0] SPACE_CHR = 8'h20;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic frame_start;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0};

    // Cells outside the 80x30 grid map to 0 so the address never leaves the RAM.
    function automatic logic [11:0] cell_addr(input logic [6:0] tcol, input logic [5:0] trow);
        if (tcol >= 7'(TEXT_COLS) || trow >= 6'(TEXT_ROWS))
            return '0;
        return 12'(trow) * 12'(TEXT_COLS) + 12'(tcol);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running pixel/line counters with raw (unpipelined) sync, display enable and frame marker.
module vga_timing_gen
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output sync_t            sync_raw
);

    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        sync_raw             = SYNC_IDLE;
        sync_raw.de          = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        sync_raw.hsync       = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
        sync_raw.vsync       = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
        sync_raw.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_text_scan.sv
// Text-mode scan engine: text RAM addressing and a 3-clk pipeline aligning glyph selectors with sync.
// Optional blinking block cursor is compiled in with VGA_TEXT_CURSOR_EN.
module vga_text_scan
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_data,
    output logic [7:0]  chr_val,
    output logic [3:0]  row,
    output logic [2:0]  col,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
`ifdef VGA_TEXT_CURSOR_EN
    ,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic        cursor_on
`endif
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    sync_t            sync_raw;
    sync_t            sync1;
    sync_t            sync2;
    sync_t            sync3;
    logic [3:0]       grow1;
    logic [2:0]       gcol1;
    logic [2:0]       gcol2;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .sync_raw (sync_raw)
    );

    // Stage 1 issues the RAM read; stage 2 meets the returned byte; stage 3 meets the glyph ROM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_addr <= '0;
            sync1     <= SYNC_IDLE;
            grow1     <= '0;
            gcol1     <= '0;
            sync2     <= SYNC_IDLE;
            row       <= '0;
            gcol2     <= '0;
            sync3     <= SYNC_IDLE;
            col       <= '0;
        end else begin
            text_addr <= sync_raw.de ? cell_addr(h_cnt[9:3], v_cnt[9:4]) : '0;
            sync1     <= sync_raw;
            grow1     <= v_cnt[3:0];
            gcol1     <= h_cnt[2:0];
            sync2     <= sync1;
            row       <= grow1;
            gcol2     <= gcol1;
            sync3     <= sync2;
            col       <= gcol2;
        end
    end

    // Control codes have no glyph, so they are shown as blanks.
    always_comb begin
        chr_val = SPACE_CHR;
        if (sync2.de && (text_data >= SPACE_CHR))
            chr_val = text_data;
    end

    assign hsync       = sync3.hsync;
    assign vsync       = sync3.vsync;
    assign de          = sync3.de;
    assign frame_start = sync3.frame_start;

`ifdef VGA_TEXT_CURSOR_EN
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [4:0] blink_cnt;
    logic       blink_on;
    logic       cur_raw;
    logic       cur1;
    logic       cur2;

    // Blink phase flips after every 32 complete frames, counted at the last pixel of each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (blink_cnt == 5'd31)
                blink_on <= ~blink_on;
        end
    end

    always_comb begin
        cur_raw = blink_on && sync_raw.de
               && (h_cnt[9:3] == cursor_x) && (v_cnt[8:4] == cursor_y)
               && (v_cnt[3:0] >= 4'd14);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur1      <= 1'b0;
            cur2      <= 1'b0;
            cursor_on <= 1'b0;
        end else begin
            cur1      <= cur_raw;
            cur2      <= cur1;
            cursor_on <= cur2;
        end
    end
`endif

endmodule

// File: tb/tb_vga_text_scan.sv
// Directed self-checking bench for vga_text_scan with a shortened vertical timing (55 lines per frame).
module tb_vga_text_scan;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VA = 48;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [7:0]  chr_val;
    logic [3:0]  row;
    logic [2:0]  col;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0]  cursor_x = 7'd5;
    logic [4:0]  cursor_y = 5'd2;
    logic        cursor_on;
`endif

    int applied = 0;
    int fails   = 0;
    int e       = 0;

    vga_text_scan #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .text_addr   (text_addr),
        .text_data   (text_data),
        .chr_val     (chr_val),
        .row         (row),
        .col         (col),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
`ifdef VGA_TEXT_CURSOR_EN
        ,
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_on   (cursor_on)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous text RAM: every cell holds 'A' except cell 100, which holds a control code.
    always @(posedge clk)
        text_data <= (text_addr == 12'd100) ? 8'h0A : 8'h41;

    function automatic bit exp_de(input int p);
        int pp = p % FRAME;
        return ((pp % HT) < HA) && ((pp / HT) < VA);
    endfunction

    function automatic int exp_addr(input int p);
        int pp = p % FRAME;
        if (!exp_de(p))
            return 0;
        return ((pp / HT) / 16) * 80 + (pp % HT) / 8;
    endfunction

    function automatic logic [7:0] exp_chr(input int p);
        if (!exp_de(p))
            return 8'h20;
        return (exp_addr(p) == 100) ? 8'h20 : 8'h41;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic goto_edge(input int target);
        if (target > e)
            step_clocks(target - e);
    endtask

    initial begin
        int de_err = 0, addr_err = 0, chr_err = 0, de_total = 0;
        int hs_first = -1, hs_low = 0, vs_low = 0, fs_cnt = 0;
        int cur_err = 0, cur_cnt = 0;
        int p;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_text_addr", 32'(text_addr), 32'd0);
        check_output("rst_row", 32'(row), 32'd0);
        check_output("rst_col", 32'(col), 32'd0);
        check_output("rst_hsync", 32'(hsync), 32'd1);
        check_output("rst_vsync", 32'(vsync), 32'd1);
        check_output("rst_de", 32'(de), 32'd0);
        check_output("rst_frame_start", 32'(frame_start), 32'd0);
        check_output("rst_chr_val", 32'(chr_val), 32'h20);

        @(negedge clk);
        rst = 1'b0;
        e = 0;
        step_clocks(1);
        check_output("start_de_e1", 32'(de), 32'd0);
        check_output("start_fs_e1", 32'(frame_start), 32'd0);
        step_clocks(1);
        check_output("start_fs_e2", 32'(frame_start), 32'd0);
        check_output("start_chr_e2", 32'(chr_val), 32'h41);
        step_clocks(1);
        check_output("start_fs_e3", 32'(frame_start), 32'd1);
        check_output("start_de_e3", 32'(de), 32'd1);
        check_output("start_col_e3", 32'(col), 32'd0);

        // One whole frame: outputs seen after edge e belong to pixel e-3, address e-1, character e-2.
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0)
                step_clocks(1);
            p = e - 3;
            if (de !== exp_de(p)) de_err++;
            if (de === 1'b1) de_total++;
            if (32'(text_addr) !== 32'(exp_addr(e - 1))) addr_err++;
            if (chr_val !== exp_chr(e - 2)) chr_err++;
            if (e < HT && hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = e;
            end
            if (vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) fs_cnt++;
`ifdef VGA_TEXT_CURSOR_EN
            begin
                int pp = p % FRAME;
                bit want = exp_de(p) && ((pp / HT) >= 46) && ((pp / HT) <= 47)
                        && ((pp % HT) >= 40) && ((pp % HT) <= 47);
                if (cursor_on !== want) cur_err++;
                if (cursor_on === 1'b1) cur_cnt++;
            end
`endif
        end
        check_output("frame_de_pattern_errors", 32'(de_err), 32'd0);
        check_output("frame_de_total", 32'(de_total), 32'(HA * VA));
        check_output("frame_addr_errors", 32'(addr_err), 32'd0);
        check_output("frame_chr_errors", 32'(chr_err), 32'd0);
        check_output("hsync_first_low", 32'(hs_first), 32'd659);
        check_output("hsync_low_width", 32'(hs_low), 32'd96);
        check_output("vsync_low_per_frame", 32'(vs_low), 32'd1600);
        check_output("frame_start_count", 32'(fs_cnt), 32'd1);
`ifdef VGA_TEXT_CURSOR_EN
        check_output("cursor_pattern_errors", 32'(cur_err), 32'd0);
        check_output("cursor_pixel_count", 32'(cur_cnt), 32'd16);
`endif

        p = FRAME + 16 * HT + 8;
        goto_edge(p + 1);
        check_output("h8v16_text_addr", 32'(text_addr), 32'd81);
        goto_edge(p + 2);
        check_output("h8v16_row", 32'(row), 32'd0);
        check_output("h8v16_chr_val", 32'(chr_val), 32'h41);
        goto_edge(p + 3);
        check_output("h8v16_col", 32'(col), 32'd0);
        check_output("h8v16_de", 32'(de), 32'd1);

        p = FRAME + 16 * HT + 160;
        goto_edge(p + 1);
        check_output("cell100_text_addr", 32'(text_addr), 32'd100);
        goto_edge(p + 2);
        check_output("ctrl_code_chr_val", 32'(chr_val), 32'h20);

        p = FRAME + 16 * HT + 700;
        goto_edge(p + 1);
        check_output("blank_text_addr", 32'(text_addr), 32'd0);
        goto_edge(p + 2);
        check_output("blank_chr_val", 32'(chr_val), 32'h20);

        p = FRAME + 17 * HT + 8;
        goto_edge(p + 2);
        check_output("h8v17_row", 32'(row), 32'd1);
        p = FRAME + 17 * HT + 13;
        goto_edge(p + 3);
        check_output("h13v17_col", 32'(col), 32'd5);

        // Reset asserted mid-cycle at line 20 must clear outputs without waiting for a clock edge.
        p = FRAME + 20 * HT + 100;
        goto_edge(p + 3);
        check_output("pre_rst_de", 32'(de), 32'd1);
        check_output("pre_rst_row", 32'(row), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_de", 32'(de), 32'd0);
        check_output("async_rst_hsync", 32'(hsync), 32'd1);
        check_output("async_rst_vsync", 32'(vsync), 32'd1);
        check_output("async_rst_text_addr", 32'(text_addr), 32'd0);
        check_output("async_rst_row", 32'(row), 32'd0);
        check_output("async_rst_col", 32'(col), 32'd0);
        check_output("async_rst_frame_start", 32'(frame_start), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        step_clocks(2);
        check_output("restart_fs_e2", 32'(frame_start), 32'd0);
        step_clocks(1);
        check_output("restart_fs_e3", 32'(frame_start), 32'd1);
        check_output("restart_de_e3", 32'(de), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule

// File: doc/vga_text_scan.md
VGA_TEXT_SCAN -- requirements
Module: vga_text_scan

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk  in  1  pixel clock (25.175 MHz); the block has one clock.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port text_addr  out  12  text RAM read address, cell = text_row*80 + text_col.
REQ-008 SHALL have port text_data  in  8  text RAM read data, valid one clk after text_addr (synchronous RAM).
REQ-009 SHALL have port chr_val  out  8  character code driven to the glyph ROM controller.
REQ-010 SHALL have port row  out  4  glyph scanline (0..15), aligned with chr_val.
REQ-011 SHALL have port col  out  3  glyph pixel column (0..7), aligned one clk after chr_val (matches glyph ROM latency).
REQ-012 SHALL have ports hsync, vsync  out  1 each  sync outputs, active-low, aligned with col.
REQ-013 SHALL have port de  out  1  display enable, high during active video, aligned with col.
REQ-014 SHALL have port frame_start  out  1  one-clk pulse, aligned with de, on pixel (0,0).

Function
REQ-015 SHALL count h_cnt 0..H_TOTAL-1 (800) every clk, wrapping to 0; v_cnt SHALL increment on h wrap, wrapping at V_TOTAL-1 (524).
REQ-016 SHALL treat counter stage as cycle N; text_addr registered at N+1; text_data arrives N+2; chr_val/row valid N+2; col/hsync/vsync/de/frame_start valid N+3; pixel latency is 3 clk.
REQ-017 SHALL compute text_col = h_cnt[9:3], text_row = v_cnt[8:4], glyph row = v_cnt[3:0], glyph col = h_cnt[2:0].
REQ-018 SHALL assert hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751, vsync low for v_cnt 490..491 (before pipeline delay).
REQ-019 SHALL assert de only when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE (before pipeline delay).
REQ-020 SHALL drive text_addr = 0 and chr_val = 8'h20 when the pipelined de is low.
REQ-021 SHALL replace text_data codes below 8'h20 with 8'h20 on chr_val (glyph ROM has no entries below 0x20).
REQ-022 SHALL keep text_addr within 0..2399 at all times.

Reset
REQ-023 SHALL, while rst high, hold h_cnt=v_cnt=0, text_addr=0, row=0, col=0, hsync=1, vsync=1, de=0, frame_start=0, and all pipeline valid bits clear.
REQ-024 SHALL, after rst deasserts mid-frame, restart from (0,0) with the pipeline flushed; the first de and frame_start appear 3 clk after the first counting edge.

Configuration
REQ-025 SHALL compile in, when VGA_TEXT_CURSOR_EN is defined: inputs cursor_x[6:0] and cursor_y[4:0], output cursor_on aligned with col; cursor_on is high on glyph rows 14..15 of the cell matching (cursor_x, cursor_y) while the blink phase is set; the blink phase toggles every 32 frames and resets to 1.
REQ-026 SHALL, when VGA_TEXT_CURSOR_EN is undefined, omit the cursor ports, blink counter and cursor logic entirely.

Structure
REQ-027 SHALL take timing defaults, H_TOTAL/V_TOTAL, TEXT_COLS=80, TEXT_ROWS=30 and SPACE_CHR=8'h20 from shared package vga_text_pkg.
REQ-028 SHALL place counters and raw sync/de generation in sub-module vga_timing_gen; address, alignment pipeline and cursor logic stay in vga_text_scan.

Verification
REQ-029 SHALL check: rst released, text RAM model all 8'h41 -> frame_start 3 clk after first edge; de high 640 clk per line for 480 lines; chr_val=8'h41.
REQ-030 SHALL check: h_cnt=8, v_cnt=16 -> text_addr=81 at N+1; row=0 at N+2; col=0 at N+3.
REQ-031 SHALL check: full frame -> hsync low 96 clk starting 659 clk after line start; vsync low exactly 1600 clk per 420000-clk frame.
REQ-032 SHALL check: text_data=8'h0A -> chr_val=8'h20; blanking region -> text_addr=0, chr_val=8'h20.
REQ-033 SHALL check: rst pulsed at v_cnt=200 -> outputs take reset values asynchronously; next frame_start 3 clk after release.
REQ-034 SHALL check (VGA_TEXT_CURSOR_EN): cursor (5,2) -> cursor_on only at lines 46..47, pixels 40..47, blink phase toggling every 32 frames.
